stream_demux4: RTL and testbench

- 1-to-4 stream router; the steering counterpart to the team's 4:1 data-select muxes.
- Accepts one valid/ready input stream with a 2-bit destination select per beat and delivers each beat to exactly one of four valid/ready output ports.
- Buffers up to 2 beats in an internal FIFO and preserves order.
- Used to fan a single producer (e.g. a response/writeback bus) out to four consumers without a combinational ready path from the consumers back to the producer.

---
 rtl/stream_demux4.sv | 156 +++++++++++++++
 tb/tb_stream_demux4.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux4.sv
// -----------------------------------------------------------------------------
// stream_demux4
//   1-to-4 valid/ready stream router with a 2-entry order-preserving FIFO.
//   Every accepted beat carries a 2-bit destination index. The beat is
//   presented to exactly one of four output ports once it reaches the head of
//   the FIFO.
//
//   The producer-side ready depends only on reset and FIFO fill level. There
//   is therefore no combinational path from out_ready back to in_ready.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst_n      : synchronous, active-low reset
//   in_valid   : input beat present
//   in_ready   : block can accept a beat this cycle (forced low in reset)
//   in_data    : input beat payload
//   in_sel     : destination port index (0..3) of the input beat
//   out_valid  : one-hot-or-zero; bit i = head beat is for port i
//   out_ready  : per-port ready; only the head's port is looked at
//   out_data   : payload of the head beat, shared by all ports
//   occupancy  : number of buffered beats (0..2)
// -----------------------------------------------------------------------------
module stream_demux4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // FIFO storage. Select and payload are held in separate arrays.
    logic [1:0]       sel_mem_r  [2];
    logic [WIDTH-1:0] data_mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;

    // Output registers. They always hold the view of the FIFO head.
    logic [3:0]       out_valid_r;
    logic [WIDTH-1:0] out_data_r;

    // Next-state signals
    logic             push_s;
    logic             pop_s;
    logic [1:0]       count_nxt_s;
    logic             rd_ptr_nxt_s;
    logic [1:0]       head_sel_nxt_s;
    logic [WIDTH-1:0] head_data_nxt_s;
    logic [3:0]       out_valid_nxt_s;
    logic [WIDTH-1:0] out_data_nxt_s;

    // Decode a port index into its one-hot valid pattern
    function automatic logic [3:0] sel_decode(input logic [1:0] sel);
        logic [3:0] onehot;
        case (sel)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

    // Ready depends only on reset and fill level, so consumers never reach
    // the producer combinationally.
    assign in_ready  = rst_n & (count_r != 2'd2);
    assign push_s    = in_valid & in_ready;
    // out_valid_r is one-hot on the head's port. Masking with out_ready
    // therefore ignores the ready bits of all non-head ports.
    assign pop_s     = |(out_valid_r & out_ready);

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign occupancy = count_r;

    // Next fill level and next read pointer
    always_comb begin
        count_nxt_s  = count_r;
        rd_ptr_nxt_s = rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
        if (pop_s) begin
            rd_ptr_nxt_s = ~rd_ptr_r;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Head entry after this edge. The beat written this edge becomes the head
    // when it lands on the next read slot (empty push, or push+pop at
    // occupancy 1).
    always_comb begin
        head_sel_nxt_s  = sel_mem_r[rd_ptr_nxt_s];
        head_data_nxt_s = data_mem_r[rd_ptr_nxt_s];
        if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_sel_nxt_s  = in_sel;
            head_data_nxt_s = in_data;
        end else begin
            head_sel_nxt_s  = sel_mem_r[rd_ptr_nxt_s];
            head_data_nxt_s = data_mem_r[rd_ptr_nxt_s];
        end
    end

    // Next registered outputs. out_data holds its last value when the FIFO
    // drains.
    always_comb begin
        out_valid_nxt_s = 4'b0000;
        out_data_nxt_s  = out_data_r;
        if (count_nxt_s != 2'd0) begin
            out_valid_nxt_s = sel_decode(head_sel_nxt_s);
            out_data_nxt_s  = head_data_nxt_s;
        end else begin
            out_valid_nxt_s = 4'b0000;
            out_data_nxt_s  = out_data_r;
        end
    end

    // FIFO state and output registers. Reset discards all buffered beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_mem_r[0]  <= 2'd0;
            sel_mem_r[1]  <= 2'd0;
            data_mem_r[0] <= '0;
            data_mem_r[1] <= '0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
            out_valid_r   <= 4'b0000;
            out_data_r    <= '0;
        end else begin
            if (push_s) begin
                sel_mem_r[wr_ptr_r]  <= in_sel;
                data_mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r             <= ~wr_ptr_r;
            end else begin
                wr_ptr_r             <= wr_ptr_r;
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
        end
    end

endmodule

// File: tb/tb_stream_demux4.sv
// -----------------------------------------------------------------------------
// tb_stream_demux4
//   Self-checking bench for stream_demux4.
//   Phase 1 applies a table of per-cycle vectors. Each row gives the inputs
//   driven during one cycle and the outputs expected in that same cycle,
//   before the next rising edge.
//   Phase 2 drives random traffic and checks the DUT against a queue-based
//   reference model.
// -----------------------------------------------------------------------------
module tb_stream_demux4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    stream_demux4 #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  ordy;
        bit          chk;
        bit          dchk;
        logic [3:0]  ov;
        logic [31:0] od;
        logic [1:0]  occ;
        logic        ir;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } beat_t;

    beat_t model_q[$];

    function automatic void add(input logic r, input logic iv, input logic [1:0] sel,
                                input logic [31:0] data, input logic [3:0] ordy,
                                input bit chk, input bit dchk, input logic [3:0] ov,
                                input logic [31:0] od, input logic [1:0] occ,
                                input logic ir);
        vec_t v;
        v.rst_n = r;  v.iv = iv;  v.sel = sel;  v.data = data;  v.ordy = ordy;
        v.chk = chk;  v.dchk = dchk;  v.ov = ov;  v.od = od;  v.occ = occ;
        v.ir = ir;
        tbl.push_back(v);
    endfunction

    task automatic check_outputs(input string tag, input logic [3:0] ov,
                                 input logic [31:0] od, input bit dchk,
                                 input logic [1:0] occ, input logic ir);
        checks++;
        if (out_valid !== ov) begin
            errors++;
            $display("FAIL %s out_valid actual=%b required=%b", tag, out_valid, ov);
        end
        checks++;
        if (occupancy !== occ) begin
            errors++;
            $display("FAIL %s occupancy actual=%0d required=%0d", tag, occupancy, occ);
        end
        checks++;
        if (in_ready !== ir) begin
            errors++;
            $display("FAIL %s in_ready actual=%b required=%b", tag, in_ready, ir);
        end
        if (dchk) begin
            checks++;
            if (out_data !== od) begin
                errors++;
                $display("FAIL %s out_data actual=%h required=%h", tag, out_data, od);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_sel = 2'd0; out_ready = 4'h0;

        // Reset. The first row runs before any edge, so its outputs are unknown.
        add(1'b0, 1'b0, 2'd0, 32'h0, 4'hF, 1'b0, 1'b0, 4'b0000, 32'h0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 1'b1, 4'b0000, 32'h0, 2'd0, 1'b0);
        // Single beat to port 2
        add(1'b1, 1'b1, 2'd2, 32'hA5A5_0001, 4'hF, 1'b1, 1'b1, 4'b0000, 32'h0, 2'd0, 1'b1);
        add(1'b1, 1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 1'b1, 4'b0100, 32'hA5A5_0001, 2'd1, 1'b1);
        add(1'b1, 1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 1'b0, 4'b0000, 32'h0, 2'd0, 1'b1);
        // Stream 8 beats at full rate. Beat k-1 is visible while beat k is pushed.
        for (int k = 0; k < 9; k++) begin
            logic [3:0] pv;
            logic [1:0] ps;
            logic [1:0] cs;
            ps = 2'(k - 1);
            cs = 2'(k);
            pv = (k == 0) ? 4'b0000 : (4'b0001 << ps);
            add(1'b1, (k < 8), cs, 32'(k), 4'hF, 1'b1, (k != 0), pv, 32'(k - 1),
                (k == 0) ? 2'd0 : 2'd1, 1'b1);
        end
        add(1'b1, 1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 1'b0, 4'b0000, 32'h0, 2'd0, 1'b1);
        // Fill with all ports stalled. Payload 99/sel3 is offered while full and must be ignored.
        add(1'b1, 1'b1, 2'd0, 32'd10, 4'h0, 1'b1, 1'b0, 4'b0000, 32'h0, 2'd0, 1'b1);
        add(1'b1, 1'b1, 2'd1, 32'd11, 4'h0, 1'b1, 1'b1, 4'b0001, 32'd10, 2'd1, 1'b1);
        add(1'b1, 1'b1, 2'd3, 32'd99, 4'h0, 1'b1, 1'b1, 4'b0001, 32'd10, 2'd2, 1'b0);
        add(1'b1, 1'b1, 2'd2, 32'd12, 4'hF, 1'b1, 1'b1, 4'b0001, 32'd10, 2'd2, 1'b0);
        add(1'b1, 1'b1, 2'd2, 32'd12, 4'hF, 1'b1, 1'b1, 4'b0010, 32'd11, 2'd1, 1'b1);
        add(1'b1, 1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 1'b1, 4'b0100, 32'd12, 2'd1, 1'b1);
        add(1'b1, 1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 1'b0, 4'b0000, 32'h0, 2'd0, 1'b1);
        // Head-of-line blocking: the head is for port 1 (stalled), the next beat for port 3 (ready).
        add(1'b1, 1'b1, 2'd1, 32'd21, 4'b1000, 1'b1, 1'b0, 4'b0000, 32'h0, 2'd0, 1'b1);
        add(1'b1, 1'b1, 2'd3, 32'd22, 4'b1000, 1'b1, 1'b1, 4'b0010, 32'd21, 2'd1, 1'b1);
        add(1'b1, 1'b0, 2'd0, 32'h0, 4'b1000, 1'b1, 1'b1, 4'b0010, 32'd21, 2'd2, 1'b0);
        add(1'b1, 1'b0, 2'd0, 32'h0, 4'b1010, 1'b1, 1'b1, 4'b0010, 32'd21, 2'd2, 1'b0);
        add(1'b1, 1'b0, 2'd0, 32'h0, 4'b1010, 1'b1, 1'b1, 4'b1000, 32'd22, 2'd1, 1'b1);
        add(1'b1, 1'b0, 2'd0, 32'h0, 4'b1010, 1'b1, 1'b0, 4'b0000, 32'h0, 2'd0, 1'b1);
        // Reset while full: the buffered beats are dropped.
        add(1'b1, 1'b1, 2'd0, 32'd40, 4'h0, 1'b1, 1'b0, 4'b0000, 32'h0, 2'd0, 1'b1);
        add(1'b1, 1'b1, 2'd1, 32'd41, 4'h0, 1'b1, 1'b1, 4'b0001, 32'd40, 2'd1, 1'b1);
        add(1'b0, 1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 1'b1, 4'b0001, 32'd40, 2'd2, 1'b0);
        add(1'b1, 1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 1'b1, 4'b0000, 32'h0, 2'd0, 1'b1);
        add(1'b1, 1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 1'b0, 4'b0000, 32'h0, 2'd0, 1'b1);
        // Simultaneous push and pop at occupancy 1
        add(1'b1, 1'b1, 2'd2, 32'd30, 4'hF, 1'b1, 1'b0, 4'b0000, 32'h0, 2'd0, 1'b1);
        add(1'b1, 1'b1, 2'd0, 32'h55, 4'hF, 1'b1, 1'b1, 4'b0100, 32'd30, 2'd1, 1'b1);
        add(1'b1, 1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 1'b1, 4'b0001, 32'h55, 2'd1, 1'b1);
        add(1'b1, 1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 1'b0, 4'b0000, 32'h0, 2'd0, 1'b1);

        // Phase 1: table vectors
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst_n     = tbl[i].rst_n;
            in_valid  = tbl[i].iv;
            in_sel    = tbl[i].sel;
            in_data   = tbl[i].data;
            out_ready = tbl[i].ordy;
            #1;
            if (tbl[i].chk) begin
                check_outputs($sformatf("vec%0d", i), tbl[i].ov, tbl[i].od,
                              tbl[i].dchk, tbl[i].occ, tbl[i].ir);
            end
        end

        // Phase 2: random traffic against a queue model. The DUT is empty here.
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic [3:0]  exp_ov;
            logic [31:0] exp_od;
            logic        exp_ir;
            bit          do_push;
            bit          do_pop;
            beat_t       nb;
            @(negedge clk);
            rst_n     = ($urandom_range(0, 49) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            out_ready = 4'($urandom_range(0, 15));
            #1;
            exp_ov = (model_q.size() != 0) ? (4'b0001 << model_q[0].sel) : 4'b0000;
            exp_od = (model_q.size() != 0) ? model_q[0].data : 32'h0;
            exp_ir = rst_n && (model_q.size() < 2);
            check_outputs($sformatf("rnd%0d", c), exp_ov, exp_od, (model_q.size() != 0),
                          2'(model_q.size()), exp_ir);
            // Advance the model to match the coming edge.
            if (!rst_n) begin
                model_q.delete();
            end else begin
                do_push = in_valid && (model_q.size() < 2);
                do_pop  = (model_q.size() != 0) && out_ready[model_q[0].sel];
                if (do_pop) void'(model_q.pop_front());
                if (do_push) begin
                    nb.sel  = in_sel;
                    nb.data = in_data;
                    model_q.push_back(nb);
                end
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
